// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with programmable almost-full/almost-empty thresholds,
// sticky overflow/underflow flags, synchronous flush and FWFT/registered read.
module sync_fifo_prog #(
   parameter int  DATA_WIDTH = 32,
   parameter int  DEPTH      = 16,
   parameter int  FWFT       = 1,
   parameter int  AF_THRESH  = DEPTH - 2,
   parameter int  AE_THRESH  = 2,
   localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  flush_i,
   input  logic                  clear_err_i,
   input  logic                  wr_en_i,
   input  logic [DATA_WIDTH-1:0] wr_data_i,
   output logic                  full_o,
   output logic                  almost_full_o,
   input  logic                  rd_en_i,
   output logic [DATA_WIDTH-1:0] rd_data_o,
   output logic                  rd_valid_o,
   output logic                  empty_o,
   output logic                  almost_empty_o,
   output logic [ADDR_WIDTH:0]   level_o,
   output logic                  overflow_o,
   output logic                  underflow_o
);

   localparam logic [ADDR_WIDTH:0]   DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0]   AF_L    = (ADDR_WIDTH+1)'(AF_THRESH);
   localparam logic [ADDR_WIDTH:0]   AE_L    = (ADDR_WIDTH+1)'(AE_THRESH);
   localparam logic [ADDR_WIDTH:0]   LVL_ONE = (ADDR_WIDTH+1)'(1);
   localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [ADDR_WIDTH:0]   level_q, level_d;
   logic                  ovf_q, ovf_d, unf_q, unf_d;
   logic                  wr_acc, rd_acc;

   // Status is decoded from the registered level only; no enable feeds a flag.
   assign full_o         = (level_q == DEPTH_L);
   assign empty_o        = (level_q == '0);
   assign almost_full_o  = (level_q >= AF_L);
   assign almost_empty_o = (level_q <= AE_L);
   assign level_o        = level_q;
   assign overflow_o     = ovf_q;
   assign underflow_o    = unf_q;

   assign wr_acc = wr_en_i && !full_o  && !flush_i;
   assign rd_acc = rd_en_i && !empty_o && !flush_i;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
         if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_ONE;
         case ({wr_acc, rd_acc})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
         endcase
      end
      // A new error in the same cycle as clear_err wins.
      ovf_d = clear_err_i ? 1'b0 : ovf_q;
      unf_d = clear_err_i ? 1'b0 : unf_q;
      if (wr_en_i && full_o  && !flush_i) ovf_d = 1'b1;
      if (rd_en_i && empty_o && !flush_i) unf_d = 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (wr_acc && !rst_i) mem_q[wr_ptr_q] <= wr_data_i;
   end

   if (FWFT != 0) begin : g_fwft
      // Gate with empty so the unreset storage never shows up on rd_data.
      assign rd_data_o  = empty_o ? '0 : mem_q[rd_ptr_q];
      assign rd_valid_o = !empty_o;
   end else begin : g_reg
      logic [DATA_WIDTH-1:0] rd_data_q;
      logic                  rd_valid_q;

      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
         end else if (flush_i) begin
            rd_valid_q <= 1'b0;
         end else begin
            rd_valid_q <= rd_acc;
            if (rd_acc) rd_data_q <= mem_q[rd_ptr_q];
         end
      end

      assign rd_data_o  = rd_data_q;
      assign rd_valid_o = rd_valid_q;
   end

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Drives one FWFT and one registered-read FIFO with identical stimulus and
// checks both against a queue-based reference model.
module tb_sync_fifo_prog;

   localparam int DW = 32;
   localparam int DEPTH = 16;
   localparam int AF = 14;
   localparam int AE = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, flush, clear_err, wr_en, rd_en;
   logic [DW-1:0] wr_data;

   logic          full1, af1, empty1, ae1, rv1, ovf1, unf1;
   logic [DW-1:0] rd1;
   logic [4:0]    lvl1;
   logic          full0, af0, empty0, ae0, rv0, ovf0, unf0;
   logic [DW-1:0] rd0;
   logic [4:0]    lvl0;

   sync_fifo_prog #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(1), .AF_THRESH(AF), .AE_THRESH(AE)) dut1 (
      .clk_i(clk), .rst_i(rst), .flush_i(flush), .clear_err_i(clear_err),
      .wr_en_i(wr_en), .wr_data_i(wr_data), .full_o(full1), .almost_full_o(af1),
      .rd_en_i(rd_en), .rd_data_o(rd1), .rd_valid_o(rv1), .empty_o(empty1),
      .almost_empty_o(ae1), .level_o(lvl1), .overflow_o(ovf1), .underflow_o(unf1));

   sync_fifo_prog #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(0), .AF_THRESH(AF), .AE_THRESH(AE)) dut0 (
      .clk_i(clk), .rst_i(rst), .flush_i(flush), .clear_err_i(clear_err),
      .wr_en_i(wr_en), .wr_data_i(wr_data), .full_o(full0), .almost_full_o(af0),
      .rd_en_i(rd_en), .rd_data_o(rd0), .rd_valid_o(rv0), .empty_o(empty0),
      .almost_empty_o(ae0), .level_o(lvl0), .overflow_o(ovf0), .underflow_o(unf0));

   int total = 0;
   int passed = 0;

   // Reference model: contents as an ordered queue, plus sticky flags and
   // the registered-read output of the FWFT=0 instance.
   logic [DW-1:0] q[$];
   logic          m_ovf = 1'b0, m_unf = 1'b0, m_v0 = 1'b0;
   logic [DW-1:0] m_d0 = '0;

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic check_all();
      int n;
      n = q.size();
      chk("level1", DW'(lvl1), DW'(n));
      chk("level0", DW'(lvl0), DW'(n));
      chk("full1", DW'(full1), DW'(n == DEPTH));
      chk("full0", DW'(full0), DW'(n == DEPTH));
      chk("empty1", DW'(empty1), DW'(n == 0));
      chk("empty0", DW'(empty0), DW'(n == 0));
      chk("afull1", DW'(af1), DW'(n >= AF));
      chk("afull0", DW'(af0), DW'(n >= AF));
      chk("aempty1", DW'(ae1), DW'(n <= AE));
      chk("aempty0", DW'(ae0), DW'(n <= AE));
      chk("ovf1", DW'(ovf1), DW'(m_ovf));
      chk("ovf0", DW'(ovf0), DW'(m_ovf));
      chk("unf1", DW'(unf1), DW'(m_unf));
      chk("unf0", DW'(unf0), DW'(m_unf));
      chk("rd_valid1", DW'(rv1), DW'(n != 0));
      if (n != 0) chk("rd_data1", rd1, q[0]);
      chk("rd_valid0", DW'(rv0), DW'(m_v0));
      chk("rd_data0", rd0, m_d0);
   endtask

   task automatic step(input logic w, input logic [DW-1:0] wd, input logic r,
                       input logic fl, input logic ce, input logic rs);
      logic was_full, was_empty, wa, ra;
      wr_en = w; wr_data = wd; rd_en = r; flush = fl; clear_err = ce; rst = rs;
      @(posedge clk);
      if (rs) begin
         q.delete();
         m_ovf = 1'b0; m_unf = 1'b0; m_v0 = 1'b0; m_d0 = '0;
      end else begin
         was_full  = (q.size() == DEPTH);
         was_empty = (q.size() == 0);
         wa = w && !was_full && !fl;
         ra = r && !was_empty && !fl;
         if (ce) begin m_ovf = 1'b0; m_unf = 1'b0; end
         if (w && was_full && !fl)  m_ovf = 1'b1;
         if (r && was_empty && !fl) m_unf = 1'b1;
         m_v0 = ra;
         if (ra) m_d0 = q[0];
         if (fl) q.delete();
         else begin
            if (ra) void'(q.pop_front());
            if (wa) q.push_back(wd);
         end
      end
      #1;
      check_all();
   endtask

   task automatic wr(input logic [DW-1:0] d); step(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0); endtask
   task automatic rd();                       step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0); endtask
   task automatic idle();                     step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0); endtask

   initial begin
      // Reset state, including rd_data of the FWFT instance.
      step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("rst_rd_data1", rd1, '0);

      // Fill 0x00..0x0F, then one extra write for overflow.
      for (int i = 0; i < DEPTH; i++) wr(DW'(i));
      wr(32'hDEAD_BEEF);

      // Drain in order, one extra read for underflow, then clear both.
      for (int i = 0; i < DEPTH; i++) rd();
      rd();
      step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);

      // Registered-read latency.
      wr(32'h0000_00A5);
      rd();
      idle();
      idle();

      // Simultaneous access at level 5, at full, at empty.
      for (int i = 0; i < 5; i++) wr(32'h100 + DW'(i));
      step(1'b1, 32'h1FF, 1'b1, 1'b0, 1'b0, 1'b0);
      while (q.size() < DEPTH) wr($urandom);
      step(1'b1, 32'h2FF, 1'b1, 1'b0, 1'b0, 1'b0);
      while (q.size() > 0) rd();
      step(1'b1, 32'h3FF, 1'b1, 1'b0, 1'b0, 1'b0);

      // Wrap-around at random rates around level 8.
      while (q.size() < 8) wr($urandom);
      for (int i = 0; i < 40; i++)
         step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);

      // Broader random mix, including occasional flush and clear_err.
      for (int i = 0; i < 300; i++)
         step(1'($urandom_range(0, 2) != 0), $urandom, 1'($urandom_range(0, 2) != 0),
              1'($urandom_range(0, 40) == 0), 1'($urandom_range(0, 20) == 0), 1'b0);

      // Flush at level 9 with both error flags set and wr_en asserted.
      while (q.size() < DEPTH) wr($urandom);
      wr($urandom);
      while (q.size() > 0) rd();
      rd();
      while (q.size() < 9) wr($urandom);
      step(1'b1, 32'h5555_5555, 1'b0, 1'b1, 1'b0, 1'b0);
      rd();

      // Reset during a registered read, and reset right after one.
      wr(32'h1234_5678);
      wr(32'h9ABC_DEF0);
      step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1);
      wr(32'h0BAD_F00D);
      rd();
      step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("rst_rd_data0", rd0, '0);
      idle();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/sync_fifo_prog.md
# sync_fifo_prog

Single-clock, parametrised FIFO with programmable almost-full/almost-empty thresholds, occupancy count, synchronous flush, sticky overflow/underflow error flags and a selectable read mode: first-word-fall-through or registered. It is the same-clock counterpart of the CDC FIFO in `ip/memory`. It buffers NPU datapath streams, such as DMA-to-PE staging and result drain, inside one clock domain, where the Gray-code synchronisers would only add latency.

## Interface
- `DATA_WIDTH`, 32, width of each stored word.
- `DEPTH`, 16, number of entries; must be a power of two and ≥ 2. `ADDR_WIDTH = $clog2(DEPTH)`.
- `FWFT`, 1, read mode. 1 = show-ahead: head word is presented without a request. 0 = registered: data returns one cycle after `rd_en`.
- `AF_THRESH`, DEPTH-2, `almost_full` asserts when `level >= AF_THRESH`. Legal range is 1..DEPTH.
- `AE_THRESH`, 2, `almost_empty` asserts when `level <= AE_THRESH`. Legal range is 0..DEPTH-1.

Ports:
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `flush` in 1: synchronous clear of FIFO contents.
- `clear_err` in 1: clears the sticky error flags.
- `wr_en` in 1: write request.
- `wr_data` in DATA_WIDTH: write data.
- `full` out 1: `level == DEPTH`.
- `almost_full` out 1: programmable full flag.
- `rd_en` in 1: read request. In FWFT mode this is the pop/acknowledge of the head word.
- `rd_data` out DATA_WIDTH: read data.
- `rd_valid` out 1: `rd_data` is valid.
- `empty` out 1: `level == 0`.
- `almost_empty` out 1: programmable empty flag.
- `level` out ADDR_WIDTH+1: occupancy, 0..DEPTH.
- `overflow` out 1: sticky; a write was attempted while full.
- `underflow` out 1: sticky; a read was attempted while empty.

## Operation
- **Storage and pointers.**
  - Storage is a DEPTH-entry array and is not reset.
  - Binary `wr_ptr`/`rd_ptr` are ADDR_WIDTH bits and wrap naturally from DEPTH-1 to 0.
  - `level` is a separate registered counter.
- **Accept rules.**
  - A write is accepted when `wr_en && !full`.
  - A read is accepted when `rd_en && !empty`.
  - No pass-through: a write while full is rejected even if a read is accepted in the same cycle. A read while empty is rejected even if a write is accepted in the same cycle.
- **Level update.**
  - Write only: +1. Read only: −1. Both accepted, or neither: unchanged.
  - `level` never leaves 0..DEPTH.
- **Status flags.** `full`, `empty`, `almost_full` and `almost_empty` are decoded only from the registered `level`. There is no combinational path from `wr_en`/`rd_en` to any status output.
- **FWFT=1.**
  - `rd_data = mem[rd_ptr]` and `rd_valid = !empty`.
  - An accepted read advances `rd_ptr`, so the next word appears in the following cycle.
- **FWFT=0.**
  - An accepted read registers `mem[rd_ptr]` into `rd_data` and pulses `rd_valid` for one cycle.
  - `rd_data` holds its last value otherwise.
  - `rd_valid` = 0 when no read was accepted in the previous cycle.
- **Errors.**
  - `overflow` sets on `wr_en && full`; `underflow` sets on `rd_en && empty`.
  - Both are cleared by `rst` or `clear_err`. If `clear_err` and a new error occur in the same cycle, the set wins.
  - `flush` does not clear the error flags.
- **Flush.**
  - Pointers and `level` go to 0 and `rd_valid` goes to 0 (FWFT=0).
  - `flush` overrides `wr_en`/`rd_en` in the same cycle: neither access is accepted and no error flag is set.
- **Reset.**
  - Pointers and `level` = 0. Therefore `empty` = 1, `full` = 0, `almost_empty` = 1, and `almost_full` = 0 unless `AF_THRESH` = 0, which is illegal.
  - `rd_data` = 0, `rd_valid` = 0, `overflow` = 0, `underflow` = 0.
  - `rst` has priority over everything, including an in-flight FWFT=0 read, which is discarded.

## Timing
- A write accepted at edge N is reflected in `level`, `empty` and the flags after edge N. In FWFT mode the word is on `rd_data` with `rd_valid` = 1 in cycle N+1, so first-word latency is 1.
- FWFT=0: read accepted at edge M gives `rd_data`/`rd_valid` in cycle M+1. Back-to-back reads give one word per cycle.
- Throughput is one write and one read per cycle.
- Full-to-not-full and empty-to-not-empty both take effect the cycle after the enabling access.
- Wrap-around: after `wr_ptr` wraps from DEPTH-1 to 0, data order is preserved; `level` alone distinguishes full from empty.

## Test plan
- **Basic fill, FWFT=1, DEPTH=16.** Reset, then write 0x00..0x0F on consecutive cycles → `full` = 1 and `level` = 16 the cycle after the 16th write; `almost_full` (AF=14) asserts after the 14th write. An extra write sets `overflow`, `level` stays 16, and contents are unchanged.
- **FWFT=1 drain.** Read 16 times → `rd_data` sequence is 0x00..0x0F. `empty` = 1 after the last read. A further `rd_en` sets `underflow`; `clear_err` clears both flags the next cycle.
- **FWFT=0 latency.** Write 0xA5, then `rd_en` one cycle later → `rd_data` = 0xA5 and `rd_valid` = 1 exactly one cycle after `rd_en`, then `rd_valid` = 0.
- **Simultaneous access.** At level 5, `wr_en` & `rd_en` → level stays 5. At full, both asserted → level becomes 15 and `overflow` = 1. At empty, both asserted → level becomes 1 and `underflow` = 1.
- **Wrap-around.** Run 40 random-rate write/read cycles at level 8 with a scoreboard → in-order data and no flag mismatch across several pointer wraps.
- **Flush and reset mid-stream.** At level 9, `flush` together with `wr_en` → level = 0, `empty` = 1, error flags unchanged. Assert `rst` during a FWFT=0 read → `rd_valid` = 0, `rd_data` = 0, `level` = 0.
